// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
//   state_t    : sequencer states (IDLE, FETCH, LAST, WRITE, DONE)
//   KERNEL     : kernel edge length
//   KTAPS      : taps per kernel (KERNEL*KERNEL)
//   REGION_*   : system address-region tags of the three BRAMs
package conv_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAST,
    WRITE,
    DONE
  } state_t;

  localparam int KERNEL = 3;
  localparam int KTAPS  = KERNEL * KERNEL;

  localparam logic [3:0] REGION_IN  = 4'h1;
  localparam logic [3:0] REGION_WT  = 4'h2;
  localparam logic [3:0] REGION_OUT = 4'h3;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Bus bundle between the convolution sequencer and its surroundings
// (register slice for start/busy/done, the input/weight BRAM read ports
// and the output BRAM write port).
//   slave  : view taken by the sequencer itself
//   master : view taken by whatever drives start and serves the BRAMs
interface conv_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
);

  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         i_ren;
  logic [ADDR_WIDTH-1:0]        i_raddr;
  logic signed [DATA_WIDTH-1:0] i_rdata;
  logic                         w_ren;
  logic [ADDR_WIDTH-1:0]        w_raddr;
  logic signed [DATA_WIDTH-1:0] w_rdata;
  logic                         o_wen;
  logic [ADDR_WIDTH-1:0]        o_waddr;
  logic [DATA_WIDTH-1:0]        o_din;

  modport slave (
    input  start, i_rdata, w_rdata,
    output busy, done, i_ren, i_raddr, w_ren, w_raddr, o_wen, o_waddr, o_din
  );

  modport master (
    output start, i_rdata, w_rdata,
    input  busy, done, i_ren, i_raddr, w_ren, w_raddr, o_wen, o_waddr, o_din
  );

endinterface

// File: rtl/conv_seq_ctrl_mac.sv
// Signed multiply-accumulate for one convolution output pixel.
//   clk, rst_n : clock, asynchronous active-low reset
//   rd_en      : read issued this cycle (data arrives next cycle)
//   clr        : zero the accumulator (takes priority over accumulate)
//   a, b       : signed pixel and weight returned by the BRAMs
//   rd_v       : rd_en delayed one cycle, i.e. a/b are valid
//   acc        : signed running sum
module conv_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 36
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_en,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic                         rd_v,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0] prod_p1;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [PROD_W-1:0] p);
    return {{(ACC_WIDTH - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Stage p1: BRAM data valid, multiply and accumulate
  assign prod_p1 = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v <= 1'b0;
      acc  <= '0;
    end else begin
      rd_v <= rd_en;
      if (clr) begin
        acc <= '0;
      end else if (rd_v) begin
        acc <= acc + sext(prod_p1);
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// 3x3 valid-convolution sequencer. Walks every output pixel in row-major
// order, reads the 9 input/weight pairs, accumulates them and writes the
// truncated sum to the output BRAM, then pulses done.
//   iclk : clock
//   irst : asynchronous active-low reset
//   bus  : conv_seq_ctrl_if.slave (start/busy/done, BRAM read ports,
//          output BRAM write port)
module conv_seq_ctrl
  import conv_seq_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 36,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                 iclk,
  input  logic                 irst,
  conv_seq_ctrl_if.slave       bus
);

  if (IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_size
    $error("conv_seq_ctrl: image must be at least 3x3");
  end
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
    $error("conv_seq_ctrl: IMG_W*IMG_H exceeds the BRAM address space");
  end

  localparam logic [ADDR_WIDTH-1:0] IMG_W_A  = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] OUT_W_A  = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_W - KERNEL);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(IMG_H - KERNEL);
  localparam logic [3:0]            K_LAST   = 4'(KTAPS - 1);
  localparam logic [1:0]            KX_LAST  = 2'(KERNEL - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   row, row_nxt;
  logic [ADDR_WIDTH-1:0]   col, col_nxt;
  logic [3:0]              k, k_nxt;
  logic [1:0]              kx, kx_nxt;
  logic [1:0]              ky, ky_nxt;

  logic                    i_ren, w_ren, o_wen, done, clr, rd_v;
  logic [ADDR_WIDTH-1:0]   i_raddr, w_raddr, o_waddr;
  logic [DATA_WIDTH-1:0]   o_din;
  logic signed [ACC_WIDTH-1:0] acc;

  // Output word is the low DATA_WIDTH bits of the sum (wraps, no saturation).
  function automatic logic [DATA_WIDTH-1:0] trunc_acc(input logic signed [ACC_WIDTH-1:0] v);
    return v[DATA_WIDTH-1:0];
  endfunction

  conv_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (iclk),
    .rst_n(irst),
    .rd_en(i_ren & w_ren),
    .clr  (clr),
    .a    (bus.i_rdata),
    .b    (bus.w_rdata),
    .rd_v (rd_v),
    .acc  (acc)
  );

  // Stage p0: state and counters
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      k     <= '0;
      kx    <= '0;
      ky    <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      k     <= k_nxt;
      kx    <= kx_nxt;
      ky    <= ky_nxt;
    end
  end

  // Outputs are decoded from the state so a reset clears the bus at once.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    k_nxt     = k;
    kx_nxt    = kx;
    ky_nxt    = ky;
    i_ren     = 1'b0;
    i_raddr   = '0;
    w_ren     = 1'b0;
    w_raddr   = '0;
    o_wen     = 1'b0;
    o_waddr   = '0;
    o_din     = '0;
    clr       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = FETCH;
          row_nxt   = '0;
          col_nxt   = '0;
          k_nxt     = '0;
          kx_nxt    = '0;
          ky_nxt    = '0;
        end
      end
      FETCH: begin
        i_ren   = 1'b1;
        w_ren   = 1'b1;
        // kx/ky track k%3 and k/3 so no divider is needed
        i_raddr = (row + ADDR_WIDTH'(ky)) * IMG_W_A + col + ADDR_WIDTH'(kx);
        w_raddr = ADDR_WIDTH'(k);
        if (k == K_LAST) begin
          state_nxt = LAST;
          k_nxt     = '0;
          kx_nxt    = '0;
          ky_nxt    = '0;
        end else begin
          k_nxt = k + 4'd1;
          if (kx == KX_LAST) begin
            kx_nxt = '0;
            ky_nxt = ky + 2'd1;
          end else begin
            kx_nxt = kx + 2'd1;
          end
        end
      end
      LAST: begin
        // final product lands in acc this cycle
        state_nxt = WRITE;
      end
      WRITE: begin
        o_wen   = 1'b1;
        o_waddr = row * OUT_W_A + col;
        o_din   = trunc_acc(acc);
        clr     = 1'b1;
        if (col == COL_LAST) begin
          col_nxt = '0;
          if (row == ROW_LAST) begin
            state_nxt = DONE;
          end else begin
            row_nxt   = row + 1'b1;
            state_nxt = FETCH;
          end
        end else begin
          col_nxt   = col + 1'b1;
          state_nxt = FETCH;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done;
  assign bus.i_ren   = i_ren;
  assign bus.i_raddr = i_raddr;
  assign bus.w_ren   = w_ren;
  assign bus.w_raddr = w_raddr;
  assign bus.o_wen   = o_wen;
  assign bus.o_waddr = o_waddr;
  assign bus.o_din   = o_din;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl on a 4x4 image.
module tb_conv_seq_ctrl;

  localparam int AW    = 15;
  localparam int DW    = 16;
  localparam int ACCW  = 36;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int NP    = (W - 2) * (H - 2);
  localparam int TOTAL = 11 * NP + 1;

  logic clk  = 1'b0;
  logic irst = 1'b0;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  conv_seq_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ACC_WIDTH (ACCW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .iclk(clk),
    .irst(irst),
    .bus (bus)
  );

  logic signed [DW-1:0] pix[W*H];
  logic signed [DW-1:0] wt[9];

  int errors = 0;
  int checks = 0;

  // monitor results of the current run
  int           wr_cnt;
  int           done_cnt;
  logic [DW-1:0] wr_data[NP];
  int           rd_trace[$];
  int           wt_trace[$];

  // model timeline: 0 = idle, 1..TOTAL = cycle index inside a run
  int m_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM models: one-cycle read latency
  always @(posedge clk) begin
    if (bus.i_ren) bus.i_rdata <= (int'(bus.i_raddr) < W*H) ? pix[int'(bus.i_raddr)] : '0;
    if (bus.w_ren) bus.w_rdata <= (int'(bus.w_raddr) < 9) ? wt[int'(bus.w_raddr)] : '0;
  end

  // Expected output pixel straight from the convolution definition
  function automatic logic [DW-1:0] model_out(input int p);
    int r, c;
    longint s;
    r = p / (W - 2);
    c = p % (W - 2);
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += longint'(pix[(r + ky) * W + c + kx]) * longint'(wt[ky * 3 + kx]);
    return s[DW-1:0];
  endfunction

  always @(posedge clk or negedge irst) begin
    if (!irst) m_t <= 0;
    else if (m_t == 0) m_t <= bus.start ? 1 : 0;
    else if (m_t == TOTAL) m_t <= 0;
    else m_t <= m_t + 1;
  end

  // Compare process: every cycle, all outputs against the timeline model
  always @(negedge clk) begin
    int p, ph, r, c;
    logic e_busy, e_done, e_ren, e_wen;
    int e_iaddr, e_waddr, e_oaddr;
    logic [DW-1:0] e_din;
    e_busy = 0; e_done = 0; e_ren = 0; e_wen = 0;
    e_iaddr = 0; e_waddr = 0; e_oaddr = 0; e_din = '0;
    if (m_t >= 1 && m_t < TOTAL) begin
      e_busy = 1;
      p  = (m_t - 1) / 11;
      ph = (m_t - 1) % 11;
      r  = p / (W - 2);
      c  = p % (W - 2);
      if (ph < 9) begin
        e_ren   = 1;
        e_iaddr = (r + ph / 3) * W + c + ph % 3;
        e_waddr = ph;
      end else if (ph == 10) begin
        e_wen   = 1;
        e_oaddr = p;
        e_din   = model_out(p);
      end
    end else if (m_t == TOTAL) begin
      e_busy = 1;
      e_done = 1;
    end
    chk("busy",    64'(bus.busy),    64'(e_busy));
    chk("done",    64'(bus.done),    64'(e_done));
    chk("i_ren",   64'(bus.i_ren),   64'(e_ren));
    chk("w_ren",   64'(bus.w_ren),   64'(e_ren));
    chk("i_raddr", 64'(bus.i_raddr), 64'(e_iaddr));
    chk("w_raddr", 64'(bus.w_raddr), 64'(e_waddr));
    chk("o_wen",   64'(bus.o_wen),   64'(e_wen));
    chk("o_waddr", 64'(bus.o_waddr), 64'(e_oaddr));
    chk("o_din",   64'(bus.o_din),   64'(e_din));
    if (irst) begin
      if (bus.o_wen) begin
        wr_cnt++;
        if (int'(bus.o_waddr) < NP) wr_data[int'(bus.o_waddr)] = bus.o_din;
      end
      if (bus.done) done_cnt++;
      if (bus.i_ren) rd_trace.push_back(int'(bus.i_raddr));
      if (bus.w_ren) wt_trace.push_back(int'(bus.w_raddr));
    end
  end

  task automatic clear_mon();
    wr_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < NP; i++) wr_data[i] = '1;
    rd_trace.delete();
    wt_trace.delete();
  endtask

  // One run: pulse (or hold) start, wait for done, return cycles start->done
  task automatic run(input bit hold_start, output int ncyc);
    bit seen;
    clear_mon();
    seen = 0;
    ncyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      ncyc++;
      if (!hold_start) bus.start = 1'b0;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    if (!seen) chk("done_timeout", 64'(0), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < W*H; i++) pix[i] = DW'($urandom);
    for (int i = 0; i < 9; i++) wt[i] = DW'($urandom);
  endtask

  initial begin
    int n;
    int exp2[4];
    int trace_exp[9];
    exp2      = '{5, 6, 9, 10};
    trace_exp = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    bus.start   = 1'b0;
    bus.i_rdata = '0;
    bus.w_rdata = '0;
    for (int i = 0; i < W*H; i++) pix[i] = '0;
    for (int i = 0; i < 9; i++) wt[i] = '0;
    clear_mon();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(bus.busy),  64'(0));
    chk("rst_ren",   64'(bus.i_ren), 64'(0));
    chk("rst_wen",   64'(bus.o_wen), 64'(0));
    chk("rst_o_din", 64'(bus.o_din), 64'(0));
    irst = 1'b1;
    repeat (2) @(negedge clk);

    // all ones: every output 9, done at cycle 45
    for (int i = 0; i < W*H; i++) pix[i] = 16'sd1;
    for (int i = 0; i < 9; i++) wt[i] = 16'sd1;
    for (int p = 0; p < NP; p++) chk("model_ones", 64'(model_out(p)), 64'(9));
    run(0, n);
    chk("t1_done_cycle", 64'(n), 64'(45));
    chk("t1_writes", 64'(wr_cnt), 64'(4));
    chk("t1_dones", 64'(done_cnt), 64'(1));
    for (int p = 0; p < NP; p++) chk("t1_data", 64'(wr_data[p]), 64'(9));

    // ramp image with centre-tap kernel; also read-address trace of pixel (1,1)
    for (int i = 0; i < W*H; i++) pix[i] = DW'(i);
    for (int i = 0; i < 9; i++) wt[i] = (i == 4) ? 16'sd1 : 16'sd0;
    for (int p = 0; p < NP; p++) chk("model_ramp", 64'(model_out(p)), 64'(exp2[p]));
    run(0, n);
    for (int p = 0; p < NP; p++) chk("t2_data", 64'(wr_data[p]), 64'(exp2[p]));
    chk("t6_trace_len", 64'(rd_trace.size()), 64'(36));
    if (rd_trace.size() == 36 && wt_trace.size() == 36) begin
      for (int i = 0; i < 9; i++) begin
        chk("t6_i_raddr", 64'(rd_trace[27 + i]), 64'(trace_exp[i]));
        chk("t6_w_raddr", 64'(wt_trace[27 + i]), 64'(i));
      end
    end

    // negative weights: -900 -> 0xFC7C
    for (int i = 0; i < W*H; i++) pix[i] = 16'sd100;
    for (int i = 0; i < 9; i++) wt[i] = -16'sd1;
    chk("model_neg", 64'(model_out(0)), 64'(16'hFC7C));
    run(0, n);
    for (int p = 0; p < NP; p++) chk("t3_data", 64'(wr_data[p]), 64'(16'hFC7C));

    // start held high for the whole run
    rand_data();
    run(1, n);
    chk("t4_dones", 64'(done_cnt), 64'(1));
    chk("t4_writes", 64'(wr_cnt), 64'(4));
    chk("t4_cycles", 64'(n), 64'(45));
    chk("t4_busy_after", 64'(bus.busy), 64'(0));

    // reset during the second pixel's fetch
    rand_data();
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13) @(negedge clk);
    chk("t5_pre_ren", 64'(bus.i_ren), 64'(1));
    #2 irst = 1'b0;
    #1;
    chk("t5_ren0",   64'(bus.i_ren),   64'(0));
    chk("t5_wren0",  64'(bus.w_ren),   64'(0));
    chk("t5_raddr0", 64'(bus.i_raddr), 64'(0));
    chk("t5_waddr0", 64'(bus.w_raddr), 64'(0));
    chk("t5_busy0",  64'(bus.busy),    64'(0));
    @(negedge clk);
    irst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt), 64'(0));
    run(0, n);
    chk("t5_cycles", 64'(n), 64'(45));
    chk("t5_writes", 64'(wr_cnt), 64'(4));
    if (rd_trace.size() > 0) chk("t5_first_raddr", 64'(rd_trace[0]), 64'(0));
    else chk("t5_trace", 64'(0), 64'(1));

    // extreme negative values
    for (int i = 0; i < W*H; i++) pix[i] = -16'sd32768;
    for (int i = 0; i < 9; i++) wt[i] = (i % 2 == 0) ? -16'sd32768 : 16'sd32767;
    run(0, n);

    // randomized runs, checked cycle by cycle against the model
    for (int t = 0; t < 8; t++) begin
      rand_data();
      run(t % 3 == 0, n);
      chk("rand_writes", 64'(wr_cnt), 64'(4));
      chk("rand_dones", 64'(done_cnt), 64'(1));
      for (int p = 0; p < NP; p++) chk("rand_data", 64'(wr_data[p]), 64'(model_out(p)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
